step_counter: RTL and testbench
===============================

STEP_COUNTER -- requirements
Module: step_counter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable synchronized samples needed to accept a button level change (10 ms at 50 MHz).
REQ-002 Parameter TICK_DIV, default 50000000, is the number of clock cycles per auto-run tick (1 Hz at 50 MHz).
REQ-003 Port CLOCK_50  in  1: the single clock; all state updates on its rising edge.
REQ-004 Port resetn  in  1: reset, asynchronous assert, active-low.
REQ-005 Port step_n  in  1: raw push-button, active-low, asynchronous, bouncy.
REQ-006 Port up  in  1: count direction level, 1=up, 0=down.
REQ-007 Port run  in  1: auto-count enable level.
REQ-008 Port load  in  1: synchronous load request level.
REQ-009 Port load_val  in  4: value loaded when load is accepted.
REQ-010 Port value  out  4: registered 4-bit count 0..15; drives the 4-bit input of the binary-to-two-digit display stage.
REQ-011 Port wrap  out  1: one-cycle pulse on count wrap-around.

Function
REQ-012 step_n, up, run and load SHALL each pass through a two-flop synchronizer before use; load_val is sampled directly on the accepting edge.
REQ-013 Button FSM states SHALL be RELEASED, ARMING, PRESSED and DISARMING; the stability counter is cleared on every state entry.
REQ-014 RELEASED: synced step_n=0 -> ARMING; otherwise stay.
REQ-015 ARMING: synced step_n=1 -> RELEASED; DEBOUNCE_CYCLES consecutive 0 samples -> PRESSED, emitting an internal one-cycle press pulse on that transition.
REQ-016 PRESSED: synced step_n=1 -> DISARMING; otherwise stay; no further press pulses while held.
REQ-017 DISARMING: synced step_n=0 -> PRESSED; DEBOUNCE_CYCLES consecutive 1 samples -> RELEASED.
REQ-018 Prescaler SHALL count 0..TICK_DIV-1 while synced run=1, emit a one-cycle tick at TICK_DIV-1, then restart at 0; it is held at 0 while synced run=0.
REQ-019 advance = press OR tick; coincident press and tick SHALL cause one step.
REQ-020 Priority: synced load > advance; on load, value <= load_val, prescaler cleared, wrap=0, and any coincident advance discarded.
REQ-021 On advance with up=1: value <= value+1 modulo 16; 15->0 asserts wrap for exactly that cycle.
REQ-022 On advance with up=0: value <= value-1 modulo 16; 0->15 asserts wrap for exactly that cycle.
REQ-023 value SHALL change only on load or advance; wrap SHALL be 0 in all other cycles.
REQ-024 A clean press SHALL update value between DEBOUNCE_CYCLES+2 and DEBOUNCE_CYCLES+4 cycles after the raw falling edge.
REQ-025 Direction change SHALL take effect on the first advance after its synchronization; no retroactive effect.
REQ-026 Releasing and re-pressing SHALL require a full DISARMING->RELEASED pass before another press pulse.

Reset
REQ-027 resetn=0 SHALL immediately force value=0, wrap=0, FSM=RELEASED, stability counter=0 and prescaler=0.
REQ-028 Reset SHALL force step_n synchronizer flops to 1 and up/run/load synchronizer flops to 0.
REQ-029 A button held through reset release SHALL produce exactly one press after DEBOUNCE_CYCLES stable samples.
REQ-030 Reset asserted mid-debounce or mid-prescale SHALL discard partial counts; no press, tick or wrap follows from pre-reset activity.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=8)
REQ-031 value=9, pulse resetn low mid-cycle -> value=0 and wrap=0 before the next clock edge.
REQ-032 step_n toggling every 2 cycles for 20 cycles, then held low 12 cycles, then high 12 cycles -> value increments by exactly 1.
REQ-033 Load 14, up=1, two clean presses -> value 15, then 0 with wrap=1 for one cycle.
REQ-034 Load 0, up=0, one clean press -> value 15, wrap=1 for one cycle.
REQ-035 run=1, up=1, from value 0 for 40 cycles -> successive increments exactly 8 cycles apart, no wrap.
REQ-036 load=1, load_val=7, coincident with a tick at value 15 -> value=7, wrap=0.

Source files
------------

// File: rtl/step_counter.sv
// Debounced single-step / auto-run 4-bit up/down counter with synchronous load.
// Button path: two-flop synchronizer feeding a four-state debounce FSM; run path: tick prescaler.
module step_counter #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned TICK_DIV        = 50000000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       step_n,
   input  logic       up,
   input  logic       run,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic [3:0] value,
   output logic       wrap
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

   localparam logic [1:0] RELEASED  = 2'd0;
   localparam logic [1:0] ARMING    = 2'd1;
   localparam logic [1:0] PRESSED   = 2'd2;
   localparam logic [1:0] DISARMING = 2'd3;

   logic [1:0]    step_sync, up_sync, run_sync, load_sync;
   logic          step_s, up_s, run_s, load_s;
   logic [1:0]    state, state_nxt;
   logic [CW-1:0] stab, stab_nxt;
   logic [PW-1:0] presc;
   logic          press, tick, advance;

   // step_n idles high, so its synchronizer resets to 1 to avoid a false press
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         step_sync <= 2'b11;
         up_sync   <= '0;
         run_sync  <= '0;
         load_sync <= '0;
      end else begin
         step_sync <= {step_sync[0], step_n};
         up_sync   <= {up_sync[0], up};
         run_sync  <= {run_sync[0], run};
         load_sync <= {load_sync[0], load};
      end
   end

   assign step_s = step_sync[1];
   assign up_s   = up_sync[1];
   assign run_s  = run_sync[1];
   assign load_s = load_sync[1];

   // stab_nxt defaults to zero so every state entry restarts the stability count
   always_comb begin
      state_nxt = state;
      stab_nxt  = '0;
      press     = 1'b0;
      case (state)
         RELEASED: begin
            if (!step_s) state_nxt = ARMING;
         end
         ARMING: begin
            if (step_s) begin
               state_nxt = RELEASED;
            end else if (stab == DB_LAST) begin
               state_nxt = PRESSED;
               press     = 1'b1;
            end else begin
               stab_nxt = stab + CW'(1);
            end
         end
         PRESSED: begin
            if (step_s) state_nxt = DISARMING;
         end
         DISARMING: begin
            if (!step_s) begin
               state_nxt = PRESSED;
            end else if (stab == DB_LAST) begin
               state_nxt = RELEASED;
            end else begin
               stab_nxt = stab + CW'(1);
            end
         end
         default: state_nxt = RELEASED;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state <= RELEASED;
         stab  <= '0;
      end else begin
         state <= state_nxt;
         stab  <= stab_nxt;
      end
   end

   assign tick    = run_s && (presc == TICK_LAST);
   assign advance = press | tick;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         presc <= '0;
      end else if (load_s || !run_s || tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // load outranks advance, so a coincident press or tick is dropped
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         value <= '0;
         wrap  <= 1'b0;
      end else if (load_s) begin
         value <= load_val;
         wrap  <= 1'b0;
      end else if (advance) begin
         if (up_s) begin
            value <= value + 4'd1;
            wrap  <= (value == 4'hF);
         end else begin
            value <= value - 4'd1;
            wrap  <= (value == 4'h0);
         end
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule

// File: tb/tb_step_counter.sv
// Randomized and directed bench for step_counter against a window-based reference model.
`timescale 1ns/1ps
module tb_step_counter;

   localparam int DB = 4;
   localparam int TD = 8;

   logic       clk = 1'b0;
   logic       resetn;
   logic       step_n;
   logic       up;
   logic       run;
   logic       load;
   logic [3:0] load_val;
   logic [3:0] value;
   logic       wrap;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int n_wrap_seen = 0;

   // reference model: button accepted when the last DB+1 synced samples all oppose the debounced level
   int m_value;
   bit m_wrap;
   bit m_deb;
   bit hist [0:DB];
   int m_pcount;
   bit m_st1, m_st2, m_up1, m_up2, m_run1, m_run2, m_ld1, m_ld2;

   step_counter #(.DEBOUNCE_CYCLES(DB), .TICK_DIV(TD)) dut (
      .CLOCK_50(clk),
      .resetn  (resetn),
      .step_n  (step_n),
      .up      (up),
      .run     (run),
      .load    (load),
      .load_val(load_val),
      .value   (value),
      .wrap    (wrap)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_value  = 0;
      m_wrap   = 1'b0;
      m_deb    = 1'b1;
      for (int i = 0; i <= DB; i++) hist[i] = 1'b1;
      m_pcount = 0;
      m_st1 = 1'b1; m_st2 = 1'b1;
      m_up1 = 1'b0; m_up2 = 1'b0;
      m_run1 = 1'b0; m_run2 = 1'b0;
      m_ld1 = 1'b0; m_ld2 = 1'b0;
   endtask

   task automatic model_step();
      bit all_opp;
      bit press;
      bit tick;
      for (int i = DB; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = m_st2;
      all_opp = 1'b1;
      for (int i = 0; i <= DB; i++) if (hist[i] == m_deb) all_opp = 1'b0;
      press = 1'b0;
      if (all_opp) begin
         m_deb = !m_deb;
         press = (m_deb == 1'b0);
      end
      tick = m_run2 && (m_pcount == TD - 1);
      if (m_ld2 || !m_run2 || tick) m_pcount = 0;
      else m_pcount = m_pcount + 1;
      if (m_ld2) begin
         m_value = int'(load_val);
         m_wrap  = 1'b0;
      end else if (press || tick) begin
         if (m_up2) begin
            m_wrap  = (m_value == 15);
            m_value = (m_value + 1) % 16;
         end else begin
            m_wrap  = (m_value == 0);
            m_value = (m_value + 15) % 16;
         end
      end else begin
         m_wrap = 1'b0;
      end
      m_st2 = m_st1;  m_st1 = step_n;
      m_up2 = m_up1;  m_up1 = up;
      m_run2 = m_run1; m_run1 = run;
      m_ld2 = m_ld1;  m_ld1 = load;
   endtask

   task automatic step_cycle();
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      check_eq("value", 32'(value), 32'(m_value));
      check_eq("wrap", 32'(wrap), 32'(m_wrap));
      if (wrap === 1'b1) n_wrap_seen++;
   endtask

   task automatic async_reset_pulse();
      #2 resetn = 1'b0;
      #1;
      model_reset();
      check_eq("rst_value", 32'(value), 32'd0);
      check_eq("rst_wrap", 32'(wrap), 32'd0);
      #1 resetn = 1'b1;
   endtask

   task automatic pulse_load(input logic [3:0] v);
      load = 1'b1;
      load_val = v;
      step_cycle();
      load = 1'b0;
      repeat (4) step_cycle();
   endtask

   task automatic press_button();
      step_n = 1'b0;
      repeat (10) step_cycle();
      step_n = 1'b1;
      repeat (10) step_cycle();
   endtask

   initial begin
      int w0;
      int changes;
      int last;
      int prev;
      bit found;

      resetn = 1'b0; step_n = 1'b1; up = 1'b1; run = 1'b0; load = 1'b0; load_val = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_value", 32'(value), 32'd0);
      check_eq("reset_wrap", 32'(wrap), 32'd0);
      resetn = 1'b1;

      // mid-cycle reset from value 9
      pulse_load(4'd9);
      check_eq("load9", 32'(value), 32'd9);
      async_reset_pulse();

      // bouncing button then clean hold/release gives one step
      pulse_load(4'd3);
      for (int i = 0; i < 10; i++) begin
         step_n = ~step_n;
         repeat (2) step_cycle();
      end
      step_n = 1'b0;
      repeat (12) step_cycle();
      step_n = 1'b1;
      repeat (12) step_cycle();
      check_eq("bounce_one_step", 32'(value), 32'd4);

      // up wrap 15 -> 0
      up = 1'b1;
      pulse_load(4'd14);
      press_button();
      check_eq("up_to_15", 32'(value), 32'd15);
      w0 = n_wrap_seen;
      press_button();
      check_eq("up_wrap_value", 32'(value), 32'd0);
      check_eq("up_wrap_pulses", 32'(n_wrap_seen - w0), 32'd1);

      // down wrap 0 -> 15
      up = 1'b0;
      pulse_load(4'd0);
      w0 = n_wrap_seen;
      press_button();
      check_eq("down_wrap_value", 32'(value), 32'd15);
      check_eq("down_wrap_pulses", 32'(n_wrap_seen - w0), 32'd1);
      up = 1'b1;
      repeat (3) step_cycle();

      // auto-run spacing
      pulse_load(4'd0);
      w0 = n_wrap_seen;
      run = 1'b1;
      changes = 0;
      last = -1;
      prev = int'(value);
      for (int i = 0; i < 40; i++) begin
         step_cycle();
         if (int'(value) != prev) begin
            if (last >= 0) check_eq("tick_gap", 32'(cyc - last), 32'(TD));
            last = cyc;
            changes++;
            prev = int'(value);
         end
      end
      check_eq("run_steps", 32'(changes), 32'd4);
      check_eq("run_no_wrap", 32'(n_wrap_seen - w0), 32'd0);
      run = 1'b0;
      repeat (3) step_cycle();

      // load coincident with a tick at value 15
      pulse_load(4'd15);
      run = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step_cycle();
         if (m_pcount == TD - 3) found = 1'b1;
      end
      check_eq("tick_align_found", 32'(found), 32'd1);
      w0 = n_wrap_seen;
      load = 1'b1;
      load_val = 4'd7;
      step_cycle();
      load = 1'b0;
      repeat (2) step_cycle();
      check_eq("load_beats_tick", 32'(value), 32'd7);
      check_eq("load_tick_no_wrap", 32'(n_wrap_seen - w0), 32'd0);
      run = 1'b0;
      repeat (3) step_cycle();

      // button held through reset release
      step_n = 1'b0;
      repeat (2) step_cycle();
      async_reset_pulse();
      repeat (20) step_cycle();
      check_eq("held_through_reset", 32'(value), 32'd1);
      step_n = 1'b1;
      repeat (12) step_cycle();
      check_eq("held_release", 32'(value), 32'd1);

      // reset mid-debounce and mid-prescale
      run = 1'b1;
      repeat (5) step_cycle();
      step_n = 1'b0;
      repeat (4) step_cycle();
      step_n = 1'b1;
      run = 1'b0;
      w0 = n_wrap_seen;
      async_reset_pulse();
      repeat (20) step_cycle();
      check_eq("partial_discarded", 32'(value), 32'd0);
      check_eq("partial_no_wrap", 32'(n_wrap_seen - w0), 32'd0);

      // randomized traffic
      for (int i = 0; i < 1200; i++) begin
         if ($urandom_range(0, 7) == 0) step_n = ~step_n;
         if ($urandom_range(0, 39) == 0) up = ~up;
         if ($urandom_range(0, 29) == 0) run = ~run;
         load = ($urandom_range(0, 49) == 0);
         load_val = 4'($urandom_range(0, 15));
         step_cycle();
         if ($urandom_range(0, 399) == 0) async_reset_pulse();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
